shift_arbiter: RTL and testbench

Shares the single 16-bit combinational universal shifter between two requesters. Round-robin arbitration, per-requester valid/ready handshakes, and registered operands and results. One transaction is in flight at a time. The block drives the shifter's data, amount and direction inputs, captures its output one cycle later, and presents a tagged response on a valid/ready response channel.

---
 rtl/shift_arbiter_if.sv | 48 ++++
 rtl/shift_arbiter.sv | 133 +++++++++++++
 tb/tb_shift_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_arbiter_if.sv
// Signal bundle between the shift arbiter, its two requesters, the external
// shifter and the response consumer. The slave modport is the arbiter's view.
interface shift_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = 5
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic [SHW-1:0]   req0_amt;
  logic             req0_right;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic [SHW-1:0]   req1_amt;
  logic             req1_right;

  logic [WIDTH-1:0] sh_a;
  logic [SHW-1:0]   sh_amt;
  logic             sh_right;
  logic [WIDTH-1:0] sh_out;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_sat;
  logic             busy;

  modport slave (
    input  req0_valid, req0_data, req0_amt, req0_right,
    input  req1_valid, req1_data, req1_amt, req1_right,
    input  sh_out, rsp_ready,
    output req0_ready, req1_ready,
    output sh_a, sh_amt, sh_right,
    output rsp_valid, rsp_id, rsp_data, rsp_sat, busy
  );

  modport master (
    output req0_valid, req0_data, req0_amt, req0_right,
    output req1_valid, req1_data, req1_amt, req1_right,
    output sh_out, rsp_ready,
    input  req0_ready, req1_ready,
    input  sh_a, sh_amt, sh_right,
    input  rsp_valid, rsp_id, rsp_data, rsp_sat, busy
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one combinational shifter between two requesters,
// with registered operands, registered tagged results and a valid/ready response.
module shift_arbiter #(
  parameter int WIDTH = 16,
  parameter int SHW   = 5
) (
  input logic            clk,
  input logic            rst,
  shift_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_r;
  logic             last_grant_r;
  logic [WIDTH-1:0] op_data_r;
  logic [SHW-1:0]   op_amt_r;
  logic             op_right_r;
  logic             op_id_r;
  logic             rsp_valid_r;
  logic             rsp_id_r;
  logic [WIDTH-1:0] rsp_data_r;
  logic             rsp_sat_r;
  logic             busy_r;

  logic             grant_valid_s;
  logic             grant_id_s;
  logic             sat_s;

  // Amount is zero-extended before comparing so any SHW works against WIDTH.
  function automatic logic amt_saturates(input logic [SHW-1:0] amt);
    logic [31:0] amt_ext;
    amt_ext = 32'(amt);
    return (amt_ext >= 32'(WIDTH));
  endfunction

  // Round-robin grant selection, only offered while idle.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (state_r == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_valid_s = 1'b1;
        grant_id_s    = ~last_grant_r;
      end else if (bus.req0_valid) begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b0;
      end else if (bus.req1_valid) begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b1;
      end else begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
      end
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  assign sat_s = amt_saturates(op_amt_r);

  assign bus.req0_ready = grant_valid_s & ~grant_id_s;
  assign bus.req1_ready = grant_valid_s &  grant_id_s;

  assign bus.sh_a      = op_data_r;
  assign bus.sh_amt    = op_amt_r;
  assign bus.sh_right  = op_right_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_sat   = rsp_sat_r;
  assign bus.busy      = busy_r;

  // Transaction FSM: accept, sample the shifter once, hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      op_data_r    <= '0;
      op_amt_r     <= '0;
      op_right_r   <= 1'b0;
      op_id_r      <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_data_r   <= '0;
      rsp_sat_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            op_data_r    <= grant_id_s ? bus.req1_data  : bus.req0_data;
            op_amt_r     <= grant_id_s ? bus.req1_amt   : bus.req0_amt;
            op_right_r   <= grant_id_s ? bus.req1_right : bus.req0_right;
            op_id_r      <= grant_id_s;
            last_grant_r <= grant_id_s;
            busy_r       <= 1'b1;
            state_r      <= SHIFT;
          end else begin
            state_r      <= IDLE;
          end
        end
        SHIFT: begin
          rsp_data_r  <= sat_s ? '0 : bus.sh_out;
          rsp_sat_r   <= sat_s;
          rsp_id_r    <= op_id_r;
          rsp_valid_r <= 1'b1;
          state_r     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r     <= RESP;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: a vector table of single transactions plus
// hand-written sequences for contention, backpressure and reset corner cases.
module tb_shift_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  shift_arbiter_if #(.WIDTH(16), .SHW(5)) bus ();

  shift_arbiter #(.WIDTH(16), .SHW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shifter stand-in; out-of-range amounts give junk so forcing to zero is visible.
  assign bus.sh_out = (bus.sh_amt >= 5'd16) ? (bus.sh_a ^ 16'hA5A5) :
                      (bus.sh_right ? (bus.sh_a >> bus.sh_amt) : (bus.sh_a << bus.sh_amt));

  typedef struct {
    logic        id;
    logic [15:0] d;
    logic [4:0]  a;
    logic        r;
    logic [15:0] ed;
    logic        es;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic id, input logic v, input logic [15:0] d,
                         input logic [4:0] a, input logic r);
    if (id) begin
      bus.req1_valid = v; bus.req1_data = d; bus.req1_amt = a; bus.req1_right = r;
    end else begin
      bus.req0_valid = v; bus.req0_data = d; bus.req0_amt = a; bus.req0_right = r;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_id"},    32'(bus.rsp_id),    32'd0);
    chk({tag, "_rsp_data"},  32'(bus.rsp_data),  32'd0);
    chk({tag, "_rsp_sat"},   32'(bus.rsp_sat),   32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_sh_a"},      32'(bus.sh_a),      32'd0);
    chk({tag, "_sh_amt"},    32'(bus.sh_amt),    32'd0);
    chk({tag, "_sh_right"},  32'(bus.sh_right),  32'd0);
  endtask

  // One complete transaction from an idle start, rsp_ready held high.
  task automatic txn(input vec_t v);
    @(negedge clk);
    set_req(v.id, 1'b1, v.d, v.a, v.r);
    bus.rsp_ready = 1'b1;
    #1;
    chk("idle_ready0", 32'(bus.req0_ready), 32'(!v.id));
    chk("idle_ready1", 32'(bus.req1_ready), 32'(v.id));
    @(negedge clk);
    set_req(v.id, 1'b0, 16'h0000, 5'd0, 1'b0);
    chk("shift_busy",     32'(bus.busy),      32'd1);
    chk("shift_rsp_vld",  32'(bus.rsp_valid), 32'd0);
    chk("shift_sh_a",     32'(bus.sh_a),      32'(v.d));
    chk("shift_sh_amt",   32'(bus.sh_amt),    32'(v.a));
    chk("shift_sh_right", 32'(bus.sh_right),  32'(v.r));
    @(negedge clk);
    chk("resp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("resp_id",    32'(bus.rsp_id),    32'(v.id));
    chk("resp_data",  32'(bus.rsp_data),  32'(v.ed));
    chk("resp_sat",   32'(bus.rsp_sat),   32'(v.es));
    @(negedge clk);
    chk("after_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("after_busy",      32'(bus.busy),      32'd0);
  endtask

  initial begin
    vecs[0] = '{id: 1'b0, d: 16'h00F0, a: 5'd4,  r: 1'b0, ed: 16'h0F00, es: 1'b0};
    vecs[1] = '{id: 1'b0, d: 16'hFFFF, a: 5'd16, r: 1'b0, ed: 16'h0000, es: 1'b1};
    vecs[2] = '{id: 1'b0, d: 16'hFFFF, a: 5'd31, r: 1'b0, ed: 16'h0000, es: 1'b1};
    vecs[3] = '{id: 1'b0, d: 16'hFFFF, a: 5'd15, r: 1'b0, ed: 16'h8000, es: 1'b0};
    vecs[4] = '{id: 1'b0, d: 16'h1234, a: 5'd0,  r: 1'b0, ed: 16'h1234, es: 1'b0};
    vecs[5] = '{id: 1'b1, d: 16'h8000, a: 5'd15, r: 1'b1, ed: 16'h0001, es: 1'b0};
    vecs[6] = '{id: 1'b1, d: 16'h1234, a: 5'd4,  r: 1'b1, ed: 16'h0123, es: 1'b0};
    vecs[7] = '{id: 1'b1, d: 16'h00FF, a: 5'd8,  r: 1'b0, ed: 16'hFF00, es: 1'b0};
    vecs[8] = '{id: 1'b0, d: 16'hFFFF, a: 5'd16, r: 1'b1, ed: 16'h0000, es: 1'b1};

    set_req(1'b0, 1'b0, 16'h0000, 5'd0, 1'b0);
    set_req(1'b1, 1'b0, 16'h0000, 5'd0, 1'b0);
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready0", 32'(bus.req0_ready), 32'd0);
    chk("reset_ready1", 32'(bus.req1_ready), 32'd0);

    for (int i = 0; i < 9; i++) txn(vecs[i]);

    // Backpressure on a right shift; req0 waits and is taken after the response.
    @(negedge clk);
    set_req(1'b1, 1'b1, 16'h8000, 5'd15, 1'b1);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    set_req(1'b1, 1'b0, 16'h0000, 5'd0, 1'b0);
    set_req(1'b0, 1'b1, 16'h1234, 5'd0, 1'b0);
    #1;
    chk("bp_shift_ready0", 32'(bus.req0_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_data",  32'(bus.rsp_data),  32'h0001);
      chk("bp_rsp_id",    32'(bus.rsp_id),    32'd1);
      chk("bp_ready0",    32'(bus.req0_ready), 32'd0);
      chk("bp_ready1",    32'(bus.req1_ready), 32'd0);
      chk("bp_busy",      32'(bus.busy),      32'd1);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_busy", 32'(bus.busy),      32'd0);
    chk("bp_release_vld",  32'(bus.rsp_valid), 32'd0);
    #1;
    chk("bp_next_ready0", 32'(bus.req0_ready), 32'd1);
    @(negedge clk);
    set_req(1'b0, 1'b0, 16'h0000, 5'd0, 1'b0);
    chk("bp_next_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("bp_next_id",   32'(bus.rsp_id),   32'd0);
    chk("bp_next_data", 32'(bus.rsp_data), 32'h1234);
    chk("bp_next_sat",  32'(bus.rsp_sat),  32'd0);
    @(negedge clk);

    // req1_valid pulses while busy and withdraws before IDLE: nothing happens.
    @(negedge clk);
    set_req(1'b0, 1'b1, 16'h00F0, 5'd4, 1'b0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 16'h0000, 5'd0, 1'b0);
    set_req(1'b1, 1'b1, 16'h5555, 5'd1, 1'b0);
    #1;
    chk("pulse_ready1", 32'(bus.req1_ready), 32'd0);
    @(negedge clk);
    set_req(1'b1, 1'b0, 16'h0000, 5'd0, 1'b0);
    chk("pulse_rsp_data", 32'(bus.rsp_data), 32'h0F00);
    repeat (2) begin
      @(negedge clk);
      chk("pulse_idle_busy", 32'(bus.busy),      32'd0);
      chk("pulse_idle_vld",  32'(bus.rsp_valid), 32'd0);
    end

    // Reset while in SHIFT discards the transaction.
    @(negedge clk);
    set_req(1'b0, 1'b1, 16'h00F0, 5'd4, 1'b0);
    @(negedge clk);
    set_req(1'b0, 1'b0, 16'h0000, 5'd0, 1'b0);
    chk("rst_shift_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("rst_shift");
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    // Contention straight after reset: grants alternate starting with 0.
    set_req(1'b0, 1'b1, 16'h0001, 5'd1, 1'b0);
    set_req(1'b1, 1'b1, 16'h0100, 5'd4, 1'b1);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_ready0", 32'(bus.req0_ready), 32'((k % 2) == 0));
      chk("cont_ready1", 32'(bus.req1_ready), 32'((k % 2) == 1));
      @(negedge clk);
      chk("cont_shift_ready0", 32'(bus.req0_ready), 32'd0);
      chk("cont_shift_ready1", 32'(bus.req1_ready), 32'd0);
      @(negedge clk);
      chk("cont_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("cont_rsp_id",    32'(bus.rsp_id),    32'(k % 2));
      chk("cont_rsp_data",  32'(bus.rsp_data),  ((k % 2) == 1) ? 32'h0010 : 32'h0002);
      @(negedge clk);
    end
    set_req(1'b0, 1'b0, 16'h0000, 5'd0, 1'b0);
    set_req(1'b1, 1'b0, 16'h0000, 5'd0, 1'b0);

    txn(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
